// File: rtl/mips_regfile_mp_if.sv
// Bus bundle for the multi-port register file: read ports, the writeback port and scoreboard marking.
// The master drives requests; the slave (the register file) returns read data and busy status.
interface mips_regfile_mp_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32,
    parameter int NUM_RD = 2
);
    localparam int AW = $clog2(DEPTH);

    logic [NUM_RD-1:0]        rd_en;
    logic [NUM_RD*AW-1:0]     rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     wr_en;
    logic [AW-1:0]            wr_addr;
    logic [DATA_W/8-1:0]      wr_be;
    logic [DATA_W-1:0]        wr_data;
    logic                     busy_set;
    logic [AW-1:0]            busy_addr;
    logic                     busy_any;

    modport master (
        output rd_en, rd_addr, wr_en, wr_addr, wr_be, wr_data, busy_set, busy_addr,
        input  rd_data, rd_busy, busy_any
    );

    modport slave (
        input  rd_en, rd_addr, wr_en, wr_addr, wr_be, wr_data, busy_set, busy_addr,
        output rd_data, rd_busy, busy_any
    );
endinterface

// File: rtl/mips_regfile_mp.sv
// Multi-port MIPS general-purpose register file with byte-lane writes, write-first read bypass
// and a per-register pending-write scoreboard used by decode to stall on outstanding loads.
module mips_regfile_mp #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32,
    parameter int NUM_RD = 2
) (
    input logic              clk,
    input logic              rst_n,
    mips_regfile_mp_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int NB = DATA_W / 8;

    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_v,
        input logic [DATA_W-1:0] new_v,
        input logic [NB-1:0]     be
    );
        logic [DATA_W-1:0] res;
        res = old_v;
        for (int k = 0; k < NB; k++) begin
            if (be[k]) begin
                res[k*8 +: 8] = new_v[k*8 +: 8];
            end else begin
                res[k*8 +: 8] = old_v[k*8 +: 8];
            end
        end
        return res;
    endfunction

    logic [DATA_W-1:0]        mem_r [DEPTH];
    logic [DEPTH-1:0]         busy_r;
    logic [DEPTH-1:0]         busy_nxt_s;
    logic                     wr_act_s;
    logic [DATA_W-1:0]        wr_merged_s;
    logic [NUM_RD*DATA_W-1:0] rd_data_r;
    logic [NUM_RD*DATA_W-1:0] rd_data_nxt_s;
    logic [NUM_RD-1:0]        rd_busy_r;
    logic [NUM_RD-1:0]        rd_busy_nxt_s;

    // Register 0 is hardwired to zero, so writes aimed at it never touch the array
    assign wr_act_s = bus.wr_en && (bus.wr_addr != {AW{1'b0}});

    // Merged value of the write target: the array content and the bypass both use it
    always_comb begin
        wr_merged_s = merge_bytes(mem_r[bus.wr_addr], bus.wr_data, bus.wr_be);
    end

    // Post-edge scoreboard: retire clears first so a same-cycle new load keeps the bit set
    always_comb begin
        busy_nxt_s = busy_r;
        if (bus.wr_en) begin
            busy_nxt_s[bus.wr_addr] = 1'b0;
        end else begin
            busy_nxt_s[bus.wr_addr] = busy_r[bus.wr_addr];
        end
        if (bus.busy_set) begin
            busy_nxt_s[bus.busy_addr] = 1'b1;
        end else begin
            busy_nxt_s[bus.busy_addr] = busy_nxt_s[bus.busy_addr];
        end
        busy_nxt_s[0] = 1'b0;
    end

    // Per-port read selection with write-first bypass and post-update busy
    always_comb begin
        logic [AW-1:0] ra_s;
        ra_s          = {AW{1'b0}};
        rd_data_nxt_s = rd_data_r;
        rd_busy_nxt_s = rd_busy_r;
        for (int p = 0; p < NUM_RD; p++) begin
            ra_s = bus.rd_addr[p*AW +: AW];
            if (bus.rd_en[p]) begin
                if (ra_s == {AW{1'b0}}) begin
                    rd_data_nxt_s[p*DATA_W +: DATA_W] = {DATA_W{1'b0}};
                end else if (wr_act_s && (ra_s == bus.wr_addr)) begin
                    rd_data_nxt_s[p*DATA_W +: DATA_W] = wr_merged_s;
                end else begin
                    rd_data_nxt_s[p*DATA_W +: DATA_W] = mem_r[ra_s];
                end
                rd_busy_nxt_s[p] = busy_nxt_s[ra_s];
            end else begin
                rd_data_nxt_s[p*DATA_W +: DATA_W] = rd_data_r[p*DATA_W +: DATA_W];
                rd_busy_nxt_s[p]                  = rd_busy_r[p];
            end
        end
    end

    // Register array and scoreboard state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < DEPTH; r++) begin
                mem_r[r] <= {DATA_W{1'b0}};
            end
            busy_r <= {DEPTH{1'b0}};
        end else begin
            if (wr_act_s) begin
                mem_r[bus.wr_addr] <= wr_merged_s;
            end else begin
                mem_r[bus.wr_addr] <= mem_r[bus.wr_addr];
            end
            busy_r <= busy_nxt_s;
        end
    end

    // Registered read ports
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_r <= {(NUM_RD*DATA_W){1'b0}};
            rd_busy_r <= {NUM_RD{1'b0}};
        end else begin
            rd_data_r <= rd_data_nxt_s;
            rd_busy_r <= rd_busy_nxt_s;
        end
    end

    assign bus.rd_data  = rd_data_r;
    assign bus.rd_busy  = rd_busy_r;
    assign bus.busy_any = |busy_r;
endmodule

// File: tb/tb_mips_regfile_mp.sv
// Scoreboard bench for mips_regfile_mp: a 32x32/2-port and a 16x64/4-port instance run side by side
// against an array-based reference model; a monitor pops expected outputs after every clock edge.
module tb_mips_regfile_mp;
    typedef struct packed {
        logic [3:0]  rd_en;
        logic [19:0] rd_addr;
        logic        wr_en;
        logic [4:0]  wr_addr;
        logic [7:0]  wr_be;
        logic [63:0] wr_data;
        logic        busy_set;
        logic [4:0]  busy_addr;
    } stim_t;

    typedef struct packed {
        logic [255:0] data;
        logic [3:0]   busy;
        logic         any;
    } exp_t;

    localparam int DW  [2] = '{32, 64};
    localparam int DEP [2] = '{32, 16};
    localparam int NRD [2] = '{2, 4};

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    logic [63:0] m_reg  [2][32];
    logic        m_busy [2][32];
    logic [63:0] m_out  [2][4];
    logic        m_ob   [2][4];
    exp_t        qa [$];
    exp_t        qb [$];

    mips_regfile_mp_if #(.DATA_W(32), .DEPTH(32), .NUM_RD(2)) ifa ();
    mips_regfile_mp_if #(.DATA_W(64), .DEPTH(16), .NUM_RD(4)) ifb ();

    mips_regfile_mp #(.DATA_W(32), .DEPTH(32), .NUM_RD(2)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    mips_regfile_mp #(.DATA_W(64), .DEPTH(16), .NUM_RD(4)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    function automatic stim_t f_wr(input stim_t s, input logic [4:0] a, input logic [7:0] be, input logic [63:0] d);
        s.wr_en = 1'b1; s.wr_addr = a; s.wr_be = be; s.wr_data = d;
        return s;
    endfunction

    function automatic stim_t f_rd(input stim_t s, input int p, input logic [4:0] a);
        s.rd_en[p] = 1'b1; s.rd_addr[p*5 +: 5] = a;
        return s;
    endfunction

    function automatic stim_t f_bs(input stim_t s, input logic [4:0] a);
        s.busy_set = 1'b1; s.busy_addr = a;
        return s;
    endfunction

    task automatic drive(input stim_t a, input stim_t b);
        ifa.rd_en     = a.rd_en[1:0];
        ifa.rd_addr   = a.rd_addr[9:0];
        ifa.wr_en     = a.wr_en;
        ifa.wr_addr   = a.wr_addr;
        ifa.wr_be     = a.wr_be[3:0];
        ifa.wr_data   = a.wr_data[31:0];
        ifa.busy_set  = a.busy_set;
        ifa.busy_addr = a.busy_addr;
        ifb.rd_en     = b.rd_en;
        ifb.rd_addr   = {b.rd_addr[18:15], b.rd_addr[13:10], b.rd_addr[8:5], b.rd_addr[3:0]};
        ifb.wr_en     = b.wr_en;
        ifb.wr_addr   = b.wr_addr[3:0];
        ifb.wr_be     = b.wr_be;
        ifb.wr_data   = b.wr_data;
        ifb.busy_set  = b.busy_set;
        ifb.busy_addr = b.busy_addr[3:0];
    endtask

    // Reference model: apply the edge's write and scoreboard rules, then reads see the result
    task automatic model_step(input int i, input stim_t s);
        if (!rst_n) begin
            for (int r = 0; r < 32; r++) begin
                m_reg[i][r] = 64'h0; m_busy[i][r] = 1'b0;
            end
            for (int p = 0; p < 4; p++) begin
                m_out[i][p] = 64'h0; m_ob[i][p] = 1'b0;
            end
        end else begin
            if (s.wr_en) begin
                if (s.wr_addr != 5'd0)
                    for (int k = 0; k < DW[i] / 8; k++)
                        if (s.wr_be[k]) m_reg[i][s.wr_addr][k*8 +: 8] = s.wr_data[k*8 +: 8];
                m_busy[i][s.wr_addr] = 1'b0;
            end
            if (s.busy_set && s.busy_addr != 5'd0) m_busy[i][s.busy_addr] = 1'b1;
            for (int p = 0; p < NRD[i]; p++) begin
                if (s.rd_en[p]) begin
                    m_out[i][p] = (s.rd_addr[p*5 +: 5] == 5'd0) ? 64'h0 : m_reg[i][s.rd_addr[p*5 +: 5]];
                    m_ob[i][p]  = m_busy[i][s.rd_addr[p*5 +: 5]];
                end
            end
        end
    endtask

    task automatic push_exp(input int i);
        exp_t e;
        e = '0;
        for (int p = 0; p < NRD[i]; p++) begin
            e.data    = e.data | ({192'h0, m_out[i][p]} << (p * DW[i]));
            e.busy[p] = m_ob[i][p];
        end
        for (int r = 0; r < DEP[i]; r++) e.any = e.any | m_busy[i][r];
        if (i == 0) qa.push_back(e);
        else qb.push_back(e);
    endtask

    task automatic cycle(input stim_t a, input stim_t b);
        drive(a, b);
        model_step(0, a); push_exp(0);
        model_step(1, b); push_exp(1);
        @(negedge clk);
    endtask

    // Monitor: after every rising edge compare both instances against the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (qa.size() > 0) begin
                e = qa.pop_front();
                chk("a_rd_data", {192'h0, ifa.rd_data}, e.data);
                chk("a_rd_busy", {254'h0, ifa.rd_busy}, {252'h0, e.busy});
                chk("a_busy_any", {255'h0, ifa.busy_any}, {255'h0, e.any});
            end
            if (qb.size() > 0) begin
                e = qb.pop_front();
                chk("b_rd_data", ifb.rd_data, e.data);
                chk("b_rd_busy", {252'h0, ifb.rd_busy}, {252'h0, e.busy});
                chk("b_busy_any", {255'h0, ifb.busy_any}, {255'h0, e.any});
            end
        end
    end

    initial begin
        stim_t z, sa, sb;
        checks = 0;
        errors = 0;
        z = '0;
        rst_n = 1'b0;
        drive(z, z);
        @(negedge clk);
        repeat (3) cycle(z, z);
        rst_n = 1'b1;

        // Asynchronous reset after writes to r5
        cycle(f_bs(f_wr(z, 5'd5, 8'h0F, 64'hCAFEF00D), 5'd5), f_bs(f_wr(z, 5'd5, 8'hFF, 64'h0123456789ABCDEF), 5'd5));
        cycle(f_rd(f_rd(z, 0, 5'd5), 1, 5'd5), f_rd(z, 0, 5'd5));
        drive(z, z);
        model_step(0, z); push_exp(0);
        model_step(1, z); push_exp(1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("a_async_rst_data", {192'h0, ifa.rd_data}, 256'h0);
        chk("a_async_rst_busy", {254'h0, ifa.rd_busy}, 256'h0);
        chk("a_async_rst_any", {255'h0, ifa.busy_any}, 256'h0);
        chk("b_async_rst_data", ifb.rd_data, 256'h0);
        chk("b_async_rst_any", {255'h0, ifb.busy_any}, 256'h0);
        @(negedge clk);
        cycle(f_wr(z, 5'd6, 8'h0F, 64'hFFFFFFFF), z);
        rst_n = 1'b1;
        cycle(f_rd(f_rd(z, 0, 5'd5), 1, 5'd6), f_rd(z, 1, 5'd5));

        // Byte-lane write merge
        cycle(f_wr(z, 5'd7, 8'h0F, 64'h11223344), z);
        cycle(f_wr(z, 5'd7, 8'h05, 64'hAABBCCDD), z);
        cycle(f_rd(z, 0, 5'd7), z);

        // Write-first bypass on both ports, full and partial lanes
        cycle(f_rd(f_rd(f_wr(z, 5'd3, 8'h0F, 64'hDEADBEEF), 0, 5'd3), 1, 5'd3), z);
        cycle(f_wr(z, 5'd3, 8'h0F, 64'h12345678), z);
        cycle(f_rd(f_rd(f_wr(z, 5'd3, 8'h03, 64'hDEADBEEF), 0, 5'd3), 1, 5'd3), z);

        // Register 0 stays zero and never busy; port 1 holds when not enabled
        cycle(f_rd(f_rd(f_bs(f_wr(z, 5'd0, 8'h0F, 64'hFFFFFFFF), 5'd0), 0, 5'd0), 1, 5'd3), z);
        sa = f_rd(z, 0, 5'd7);
        sa.rd_addr[9:5] = 5'd7;
        cycle(sa, z);

        // Scoreboard set, set-wins-over-clear, then retire
        cycle(f_bs(z, 5'd9), z);
        cycle(f_rd(z, 0, 5'd9), z);
        cycle(f_rd(f_bs(f_wr(z, 5'd9, 8'h0F, 64'h99), 5'd9), 1, 5'd9), z);
        cycle(f_rd(f_wr(z, 5'd9, 8'h0F, 64'h9A), 0, 5'd9), z);
        cycle(z, z);

        // Wide instance: four concurrent reads and an 8-lane merge
        cycle(z, f_wr(z, 5'd1, 8'hFF, 64'h1111111111111111));
        cycle(z, f_wr(z, 5'd2, 8'hFF, 64'h2222222222222222));
        cycle(z, f_wr(z, 5'd3, 8'hFF, 64'h3333333333333333));
        cycle(z, f_wr(z, 5'd4, 8'hFF, 64'h4444444444444444));
        cycle(z, f_rd(f_rd(f_rd(f_rd(z, 0, 5'd1), 1, 5'd2), 2, 5'd3), 3, 5'd4));
        cycle(z, f_wr(z, 5'd2, 8'hA5, 64'hAABBCCDDEEFF0011));
        cycle(z, f_rd(f_rd(z, 2, 5'd2), 3, 5'd15));

        // Randomized traffic biased towards address collisions
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 2; i++) begin
                stim_t s;
                s = '0;
                s.wr_en     = ($urandom_range(0, 1) == 1);
                s.wr_addr   = 5'($urandom_range(0, DEP[i] - 1));
                s.wr_be     = 8'($urandom_range(0, 255));
                s.wr_data   = {$urandom(), $urandom()};
                s.busy_set  = ($urandom_range(0, 3) == 0);
                s.busy_addr = ($urandom_range(0, 2) == 0) ? s.wr_addr : 5'($urandom_range(0, DEP[i] - 1));
                for (int p = 0; p < NRD[i]; p++) begin
                    s.rd_en[p] = ($urandom_range(0, 3) != 0);
                    s.rd_addr[p*5 +: 5] = ($urandom_range(0, 2) == 0) ? s.wr_addr
                                                                      : 5'($urandom_range(0, DEP[i] - 1));
                end
                if (i == 0) sa = s;
                else sb = s;
            end
            cycle(sa, sb);
        end

        cycle(z, z);
        @(posedge clk);
        #2;
        chk("a_queue_drained", 256'(qa.size()), 256'h0);
        chk("b_queue_drained", 256'(qb.size()), 256'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mips_regfile_mp.md
# mips_regfile_mp

Parametrised multi-port general-purpose register file for the pipelined MIPS core, sitting between decode (read ports) and writeback (write port). It extends the earlier single-pair register file with a configurable number of registered read ports, byte-lane writes with same-cycle write-first bypass, an asynchronous clear, and a per-register pending-write scoreboard. Decode uses the scoreboard to stall on outstanding loads.

## Interface
- DATA_W, 32, register width in bits; must be a multiple of 8
- DEPTH, 32, number of registers; power of two, at least 2
- NUM_RD, 2, number of independent read ports, 1..4
- AW (localparam), $clog2(DEPTH), address width
- clk  in  1  sole clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous and active-low
- rd_en  in  NUM_RD  per-port read strobe
- rd_addr  in  NUM_RD*AW  port p address in bits [p*AW +: AW]
- rd_data  out  NUM_RD*DATA_W  port p data in [p*DATA_W +: DATA_W], registered
- rd_busy  out  NUM_RD  port p scoreboard bit for the address read, registered
- wr_en  in  1  write strobe
- wr_addr  in  AW  write address
- wr_be  in  DATA_W/8  byte-lane enables; bit k covers bits [8k+7:8k]
- wr_data  in  DATA_W  write data
- busy_set  in  1  mark busy_addr as having a pending write (load issued)
- busy_addr  in  AW  address to mark
- busy_any  out  1  OR of all scoreboard bits, combinational from state

## Operation
- Storage: DEPTH x DATA_W array plus a DEPTH-bit scoreboard.
- Register 0 reads as 0 and its busy bit reads as 0. Writes and busy_set targeting address 0 are dropped.
- Write: when wr_en=1, wr_addr!=0 and wr_be[k]=1, byte k of register wr_addr takes byte k of wr_data at the edge. Unselected bytes hold. wr_en=1 with wr_be=0 changes no data but still clears the busy bit.
- Scoreboard: wr_en=1 clears busy[wr_addr]. busy_set=1 sets busy[busy_addr]. If both target the same address in the same cycle, set wins: a new load is issued as the old one retires.
- Read: when rd_en[p]=1, rd_data[p] and rd_busy[p] load at the edge. When rd_en[p]=0, both hold their previous values.
- Bypass (write-first): a read in the same cycle as a write to the same nonzero address returns the merged value. Enabled bytes come from wr_data; other bytes come from the stored register. rd_busy returns the post-update busy bit, so the same-cycle set/clear rules above apply.
- Ports are fully independent. Any number may read the same address, including the write address.
- Addresses ≥ DEPTH cannot occur (DEPTH is a power of two).

## Timing
- Reset (rst_n=0, asynchronous, no clock needed): all registers become 0, all busy bits 0, rd_data 0, rd_busy 0, busy_any 0. This holds for as long as rst_n is low.
- Reset mid-operation: a write or busy_set on the deasserting edge's cycle has no effect if rst_n is still low at that edge. The first effective edge is the first rising clk with rst_n=1.
- Read latency is 1 cycle: address presented in cycle N, data visible after edge N+1.
- Write visibility: a write at edge N is seen by a read issued in cycle N through the bypass. It is seen by a read issued in cycle N+1 from the array.
- busy_any reflects scoreboard state after the most recent edge.
- No combinational path runs from any input to rd_data or rd_busy.

## Test plan
- Reset: rst_n=0 asynchronously mid-cycle after writes to r5 -> rd_data, rd_busy and busy_any are 0 immediately. A read of r5 after release returns 0x00000000.
- Byte write: r7=0x11223344, then write wr_be=4'b0101 with 0xAABBCCDD -> read of r7 returns 0x11BB33DD one cycle later.
- Bypass: in a single cycle write r3=0xDEADBEEF with wr_be=4'hF, and read r3 on ports 0 and 1 -> both return 0xDEADBEEF after that edge. With wr_be=4'b0011 over a prior value 0x12345678, both return 0x1234BEEF.
- Register 0 and hold: write r0=0xFFFFFFFF plus busy_set on r0 -> read r0 gives 0 with rd_busy 0 and busy_any 0. Then drop rd_en on port 1 while changing its address -> rd_data[1] holds its previous value.
- Scoreboard: busy_set r9, then read r9 -> rd_busy=1 and busy_any=1. In one cycle write r9 and busy_set r9 -> busy stays 1. Next cycle write r9 without busy_set -> a same-cycle read gives rd_busy=0, and busy_any=0 once no other bits are set.
- Parameters: run with DATA_W=64, DEPTH=16, NUM_RD=4 -> all four ports read distinct registers concurrently, and an 8-lane byte write merges correctly.
